// File: rtl/mux4a1_pkg.sv
// Shared constants, state encoding and one-hot helper for the 4:1 round-robin arbiter.
// Purely declarative: no latency or flow control of its own.
package mux4a1_pkg;

    localparam int NUM_REQ       = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mux4a1_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr (mod 4), one-hot or zero.
// Combinational, zero latency; no flow control.
module mux4a1_rr_pick
    import mux4a1_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] onehot
);

    function automatic logic [NUM_REQ-1:0] scan(input logic [NUM_REQ-1:0] v,
                                                input logic [1:0]         p);
        logic [NUM_REQ-1:0] res;
        logic               found;
        logic [1:0]         idx;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = p + 2'(k);
            if (!found && v[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        onehot = scan(valid, ptr);
    end

endmodule

// File: rtl/mux4a1_rr_arbiter.sv
// Round-robin burst arbiter feeding one registered output stage; 2 cycles valid_in to valid_out.
// Backpressure: out_ready low with valid_out high freezes data, grant and burst count.
module mux4a1_rr_arbiter
    import mux4a1_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                clkf,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  valid_in,
    input  logic [DATA_W-1:0]   data_in0,
    input  logic [DATA_W-1:0]   data_in1,
    input  logic [DATA_W-1:0]   data_in2,
    input  logic [DATA_W-1:0]   data_in3,
    output logic [NUM_REQ-1:0]  ready_out,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                valid_out,
    output logic [NUM_REQ-1:0]  grant,
    output logic                idle
);

    localparam int              CNT_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;

    logic               load;
    logic               accept;
    logic               rotate;
    logic [1:0]         owner;
    logic [1:0]         pick_ptr;
    logic [NUM_REQ-1:0] pick_oh;
    logic [DATA_W-1:0]  owner_dat;

    assign load      = ~valid_q | out_ready;
    assign ready_out = grant_q & {NUM_REQ{load}};
    assign accept    = |(valid_in & ready_out);
    assign owner     = onehot_idx(grant_q);

    // Owner dropping valid rotates even during a stall; a full burst rotates on its last beat.
    assign rotate    = ~valid_in[owner] | (accept && (cnt_q == CNT_LAST));

    // In GRANT the pick already uses the post-rotation pointer so the owner ends up last.
    assign pick_ptr  = (state_q == ST_IDLE) ? ptr_q : 2'(owner + 2'd1);

    always_comb begin
        owner_dat = data_in0;
        case (owner)
            2'd1:    owner_dat = data_in1;
            2'd2:    owner_dat = data_in2;
            2'd3:    owner_dat = data_in3;
            default: owner_dat = data_in0;
        endcase
    end

    mux4a1_rr_pick u_pick (
        .valid  (valid_in),
        .ptr    (pick_ptr),
        .onehot (pick_oh)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (accept) begin
            data_d  = owner_dat;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|valid_in) begin
                    grant_d = pick_oh;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rotate) begin
                    ptr_d   = 2'(owner + 2'd1);
                    grant_d = pick_oh;
                    cnt_d   = '0;
                    if (pick_oh == '0) begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkf) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign grant     = grant_q;
    assign idle      = (grant_q == '0);

endmodule

// File: tb/tb_mux4a1_rr_arbiter.sv
// Directed bench for mux4a1_rr_arbiter: per-lane source queues, expected-beat and
// expected-grant scoreboards checked by an independent monitor.
module tb_mux4a1_rr_arbiter;

    typedef logic [7:0] bq_t[$];

    logic       clkf = 1'b0;
    logic       reset;
    logic [3:0] valid_in;
    logic [7:0] lane_dat [4];
    logic [3:0] ready_out;
    logic       out_ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic [3:0] grant;
    logic       idle;

    bq_t        lane_q [4];
    logic [7:0] exp_d[$];
    logic [3:0] exp_g[$];
    logic [3:0] fire   = 4'b0;
    logic [3:0] last_g = 4'b0;
    logic       mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clkf = ~clkf;

    mux4a1_rr_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
        .clkf      (clkf),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in0  (lane_dat[0]),
        .data_in1  (lane_dat[1]),
        .data_in2  (lane_dat[2]),
        .data_in3  (lane_dat[3]),
        .ready_out (ready_out),
        .out_ready (out_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant     (grant),
        .idle      (idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    // Sources: present queue head, pop once the handshake seen before the edge has happened.
    initial begin
        valid_in = 4'b0;
        for (int i = 0; i < 4; i++) lane_dat[i] = 8'h00;
        forever begin
            @(negedge clkf);
            for (int i = 0; i < 4; i++) begin
                if (fire[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
                valid_in[i] = (lane_q[i].size() > 0);
                lane_dat[i] = (lane_q[i].size() > 0) ? lane_q[i][0] : 8'h00;
            end
            #1;
            fire = valid_in & ready_out;
        end
    end

    // Monitor: output beats and grant changes against the scoreboards, plus invariants.
    initial begin
        forever begin
            @(negedge clkf);
            #1;
            if (mon_en) begin
                chk("idle_vs_grant", 32'(idle), 32'(grant == 4'b0));
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                chk("ready_onehot0", 32'($onehot0(ready_out)), 32'd1);
                if (valid_out && out_ready) begin
                    if (exp_d.size() == 0) fail_now("unexpected_beat", 32'(data_out));
                    else chk("data_out", 32'(data_out), 32'(exp_d.pop_front()));
                end
                if (grant != last_g && grant != 4'b0) begin
                    if (exp_g.size() == 0) fail_now("unexpected_grant", 32'(grant));
                    else chk("grant_seq", 32'(grant), 32'(exp_g.pop_front()));
                end
                last_g = grant;
            end
        end
    end

    function automatic bit lanes_busy();
        for (int i = 0; i < 4; i++) if (lane_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clkf);
        #2;
    endtask

    // Called two time units after an edge; asserts reset for two edges and checks reset outputs.
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) begin
            step();
            chk("rst_data_out", 32'(data_out), 32'h00);
            chk("rst_valid_out", 32'(valid_out), 32'd0);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
            chk("rst_ready_out", 32'(ready_out), 32'd0);
        end
        for (int i = 0; i < 4; i++) lane_q[i].delete();
        exp_d.delete();
        exp_g.delete();
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_d.size() != 0 || exp_g.size() != 0 || lanes_busy() ||
                grant != 4'b0 || valid_out) && n < 300) begin
            step();
            n++;
        end
        chk(name, 32'(n < 300), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset with every requester valid.
        for (int i = 0; i < 4; i++) lane_q[i].push_back(8'hEE);
        do_reset();
        mon_en = 1'b1;

        // Single requester 2 streams A0..A5 across a burst boundary.
        for (int k = 0; k < 6; k++) begin
            lane_q[2].push_back(8'hA0 + 8'(k));
            exp_d.push_back(8'hA0 + 8'(k));
        end
        exp_g.push_back(4'b0100);
        step();
        chk("single_grant", 32'(grant), 32'b0100);
        repeat (6) begin
            step();
            chk("single_nogap", 32'(valid_out), 32'd1);
        end
        wait_drain("single_drain");

        // Fairness: all four lanes, 8 beats each, bursts of 4.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) lane_q[i].push_back(8'((i << 4) | k));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                exp_g.push_back(4'(1 << i));
                for (int k = 0; k < 4; k++) exp_d.push_back(8'((i << 4) | (r * 4 + k)));
            end
        step();
        chk("fair_first_grant", 32'(grant), 32'b0001);
        wait_drain("fair_drain");

        // Backpressure: 0x11 held three cycles, then 0x12 follows.
        do_reset();
        lane_q[1].push_back(8'h11);
        lane_q[1].push_back(8'h12);
        exp_d.push_back(8'h11);
        exp_d.push_back(8'h12);
        exp_g.push_back(4'b0010);
        step();
        chk("bp_grant", 32'(grant), 32'b0010);
        step();
        chk("bp_first_data", 32'(data_out), 32'h11);
        out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_hold_data", 32'(data_out), 32'h11);
            chk("bp_hold_valid", 32'(valid_out), 32'd1);
            chk("bp_hold_ready", 32'(ready_out), 32'd0);
            chk("bp_hold_grant", 32'(grant), 32'b0010);
        end
        out_ready = 1'b1;
        step();
        chk("bp_second_data", 32'(data_out), 32'h12);
        chk("bp_second_valid", 32'(valid_out), 32'd1);
        wait_drain("bp_drain");

        // Early release: lane 0 sends one beat and drops, lane 3 takes over after one bubble.
        do_reset();
        lane_q[0].push_back(8'hB0);
        lane_q[3].push_back(8'hC0);
        lane_q[3].push_back(8'hC1);
        exp_d.push_back(8'hB0);
        exp_d.push_back(8'hC0);
        exp_d.push_back(8'hC1);
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b1000);
        step();
        chk("er_grant0", 32'(grant), 32'b0001);
        step();
        chk("er_beat_b0", 32'(data_out), 32'hB0);
        step();
        chk("er_bubble_valid", 32'(valid_out), 32'd0);
        chk("er_grant3", 32'(grant), 32'b1000);
        step();
        chk("er_beat_c0", 32'(data_out), 32'hC0);
        chk("er_beat_c0_valid", 32'(valid_out), 32'd1);
        wait_drain("er_drain");
        lane_q[1].push_back(8'hD1);
        lane_q[0].push_back(8'hE0);
        exp_d.push_back(8'hE0);
        exp_d.push_back(8'hD1);
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0010);
        step();
        chk("er_ptr_favours_0", 32'(grant), 32'b0001);
        wait_drain("er_drain2");

        // Reset in the middle of a burst from lane 1.
        do_reset();
        lane_q[1].push_back(8'h51);
        lane_q[1].push_back(8'h52);
        lane_q[1].push_back(8'h53);
        exp_d.push_back(8'h51);
        exp_g.push_back(4'b0010);
        step();
        chk("mb_grant", 32'(grant), 32'b0010);
        step();
        chk("mb_first_beat", 32'(data_out), 32'h51);
        do_reset();
        lane_q[0].push_back(8'h61);
        lane_q[1].push_back(8'h71);
        exp_d.push_back(8'h61);
        exp_d.push_back(8'h71);
        exp_g.push_back(4'b0001);
        exp_g.push_back(4'b0010);
        step();
        chk("mb_ptr0_wins", 32'(grant), 32'b0001);
        wait_drain("mb_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
